pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL provide port clk  input  1  single system clock, all state on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous active-high reset.
REQ-004 SHALL provide port next_pc  input  32  next instruction address from the next-PC logic, sampled only in EXEC.
REQ-005 SHALL provide port stall  input  1  holds the current instruction in EXEC when high.
REQ-006 SHALL provide port imem_req  output  1  instruction-memory read request.
REQ-007 SHALL provide port imem_addr  output  32  instruction-memory read address.
REQ-008 SHALL provide port imem_ack  input  1  memory read-data-valid strobe.
REQ-009 SHALL provide port imem_rdata  input  32  memory read data, valid when imem_ack=1.
REQ-010 SHALL provide port pc  output  32  address of the current instruction, feeding the next-PC logic.
REQ-011 SHALL provide port instruction  output  32  latched current instruction word.
REQ-012 SHALL provide port instr_valid  output  1  instruction and pc are valid for execution.
REQ-013 SHALL provide port retire_count  output  32  count of retired instructions.
REQ-014 SHALL provide port misalign  output  1  sticky misaligned-target fault flag.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, EXEC, HALT; one-state-per-cycle transitions on clk.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then move to FETCH.
REQ-017 FETCH SHALL drive imem_req=1 and imem_addr=pc, both held stable every cycle until imem_ack=1.
REQ-018 On imem_ack=1 in FETCH, instruction SHALL capture imem_rdata and the FSM SHALL move to EXEC next cycle.
REQ-019 imem_ack outside FETCH SHALL be ignored; stall SHALL be ignored in FETCH.
REQ-020 EXEC SHALL drive instr_valid=1 and imem_req=0; instruction and pc SHALL remain constant.
REQ-021 EXEC with stall=1 SHALL remain in EXEC with no state change other than holding.
REQ-022 EXEC with stall=0 SHALL retire: pc<=next_pc, retire_count<=retire_count+1, FSM->FETCH.
REQ-023 retire_count SHALL wrap from 32'hFFFF_FFFF to 0 without flag.
REQ-024 Zero-wait memory (ack in first FETCH cycle) SHALL yield one instruction every 2 cycles.
REQ-025 instr_valid and imem_req SHALL never both be 1 in the same cycle.
REQ-026 HALT SHALL drive imem_req=0, instr_valid=0 and hold all registers until reset.

Reset
REQ-027 reset=1 SHALL immediately (asynchronously) force state=IDLE, pc=RESET_PC, instruction=0, retire_count=0, misalign=0, imem_req=0, instr_valid=0, imem_addr=RESET_PC.
REQ-028 reset asserted mid-FETCH SHALL abandon the request; a late imem_ack after release SHALL be ignored (arrives in IDLE).

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN SHALL, when defined, check next_pc[1:0] on retire: nonzero -> misalign<=1, pc unchanged, retire_count still increments, FSM->HALT.
REQ-030 Without PC_ALIGN_CHECK_EN, retire SHALL load pc<={next_pc[31:2],2'b00}, misalign SHALL be tied 0 and HALT SHALL be unreachable.

Verification
REQ-031 Reset, zero-wait memory returning 32'h2002_0005, next_pc=pc+4 -> pc sequence 0,4,8 with instr_valid high every second cycle, retire_count=3 after 6 cycles from first FETCH.
REQ-032 imem_ack delayed 3 cycles at pc=32'h0000_0010 -> imem_req and imem_addr=32'h10 stable for 4 cycles, instruction captured on ack cycle.
REQ-033 stall=1 for 5 cycles in EXEC with next_pc=32'h40 -> pc, instruction held, retire_count unchanged; retire in cycle stall drops, next FETCH at 32'h40.
REQ-034 retire_count preloaded to 32'hFFFF_FFFF via 2^32-retire-equivalent force -> one retire gives 0.
REQ-035 With PC_ALIGN_CHECK_EN, next_pc=32'h0000_0102 at retire -> misalign=1, HALT, pc unchanged, no further imem_req; without macro -> pc=32'h100.
REQ-036 reset pulsed during FETCH with ack arriving 1 cycle after release -> ack ignored, instruction=0, fresh FETCH at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: IDLE -> FETCH -> EXEC loop with retire counting.
// Optional target-alignment fault (misalign flag, HALT state) enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] retire_count,
    output logic        misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic [31:0] r_retire_count;
    logic        r_imem_req;
    logic        r_instr_valid;

    logic        w_capture;
    logic        w_retire;
    logic        w_misaligned;
    logic [31:0] w_pc_aligned;

    assign w_capture    = (r_state == FETCH) && imem_ack;
    assign w_retire     = (r_state == EXEC) && !stall;
    assign w_pc_aligned = {next_pc[31:2], 2'b00};

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_misaligned = |next_pc[1:0];

    // Sticky fault: only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_retire && w_misaligned) begin
            r_misalign <= 1'b1;
        end
    end

    assign misalign = r_misalign;
`else
    logic w_unused_lsb;

    assign w_misaligned = 1'b0;
    assign w_unused_lsb = ^next_pc[1:0];
    assign misalign     = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  w_state_nxt = FETCH;
            FETCH: if (imem_ack) w_state_nxt = EXEC;
            EXEC:  if (!stall) w_state_nxt = w_misaligned ? HALT : FETCH;
            HALT:  w_state_nxt = HALT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_imem_req    <= (w_state_nxt == FETCH);
            r_instr_valid <= (w_state_nxt == EXEC);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instruction <= 32'h0000_0000;
        end else if (w_capture) begin
            r_instruction <= imem_rdata;
        end
    end

    // A misaligned target keeps the faulting pc visible for debug.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_retire && !w_misaligned) begin
            r_pc <= w_pc_aligned;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_retire_count <= 32'h0000_0000;
        end else if (w_retire) begin
            r_retire_count <= r_retire_count + 32'd1;
        end
    end

    assign imem_req     = r_imem_req;
    assign imem_addr    = r_pc;
    assign pc           = r_pc;
    assign instruction  = r_instruction;
    assign instr_valid  = r_instr_valid;
    assign retire_count = r_retire_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table, directed corner sequences and a random scoreboard run.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] retire_count;
    logic        misalign;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .reset        (reset),
        .next_pc      (next_pc),
        .stall        (stall),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .pc           (pc),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .retire_count (retire_count),
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int unsigned lat;
        logic [31:0] rdata;
        int unsigned stalls;
        logic [31:0] nxt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        next_pc    = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_count", retire_count, 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        reset = 1'b0;
    endtask

    // Waits (bounded) at negedges for imem_req (want_valid=0) or instr_valid (want_valid=1).
    task automatic wait_sig(input bit want_valid, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (want_valid ? instr_valid : imem_req) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: timeout waiting, got 0 expected 1", name);
        end
    endtask

    task automatic fetch_one(input logic [31:0] data);
        wait_sig(1'b0, "fetch_wait_req");
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_ack   = 1'b0;
        chk("fetch_valid", 32'(instr_valid), 32'h1);
        chk("fetch_instr", instruction, data);
    endtask

    initial begin
        logic [31:0] cur;
        logic [31:0] cnt;
        logic [31:0] exp_instr;
        logic        prev_req;
        int unsigned lat;

        vecs[0] = '{lat: 0, rdata: 32'h1111_1111, stalls: 0, nxt: 32'h0000_0010, exp_pc: 32'h0000_0010};
        vecs[1] = '{lat: 3, rdata: 32'h2222_2222, stalls: 0, nxt: 32'h0000_0020, exp_pc: 32'h0000_0020};
        vecs[2] = '{lat: 1, rdata: 32'h3333_3333, stalls: 5, nxt: 32'h0000_0040, exp_pc: 32'h0000_0040};
        vecs[3] = '{lat: 2, rdata: 32'h4444_4444, stalls: 1, nxt: 32'h0000_0100, exp_pc: 32'h0000_0100};
        vecs[4] = '{lat: 0, rdata: 32'h5555_5555, stalls: 2, nxt: 32'hFFFF_FFFC, exp_pc: 32'hFFFF_FFFC};
        vecs[5] = '{lat: 4, rdata: 32'h6666_6666, stalls: 0, nxt: 32'h0000_0000, exp_pc: 32'h0000_0000};

        // Zero-wait memory with sequential next_pc: one instruction every 2 cycles.
        apply_reset();
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            chk("zw_valid", 32'(instr_valid), 32'(k % 2));
            chk("zw_req", 32'(imem_req), 32'((k + 1) % 2));
            if (imem_req) begin
                imem_ack   = 1'b1;
                imem_rdata = 32'h2002_0005;
            end else begin
                imem_ack   = 1'b0;
            end
            if (instr_valid) begin
                chk("zw_pc", pc, 32'(4 * (k / 2)));
                chk("zw_instr", instruction, 32'h2002_0005);
                next_pc = 32'(4 * (k / 2) + 4);
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        chk("zw_count", retire_count, 32'd3);

        // Table of fetch/exec transactions with wait states and stalls.
        apply_reset();
        cur = RESET_PC;
        cnt = 32'h0;
        foreach (vecs[v]) begin
            wait_sig(1'b0, "tbl_wait_req");
            for (int w = 0; w <= int'(vecs[v].lat); w++) begin
                chk("tbl_req", 32'(imem_req), 32'h1);
                chk("tbl_addr", imem_addr, cur);
                chk("tbl_nvalid", 32'(instr_valid), 32'h0);
                imem_ack   = (w == int'(vecs[v].lat));
                imem_rdata = imem_ack ? vecs[v].rdata : $urandom;
                stall      = 1'(($urandom % 2));
                @(negedge clk);
            end
            imem_ack = 1'b0;
            chk("tbl_valid", 32'(instr_valid), 32'h1);
            chk("tbl_instr", instruction, vecs[v].rdata);
            chk("tbl_pc", pc, cur);
            chk("tbl_count", retire_count, cnt);
            for (int s = 0; s < int'(vecs[v].stalls); s++) begin
                stall    = 1'b1;
                next_pc  = $urandom;
                imem_ack = 1'b1;
                @(negedge clk);
                chk("stall_valid", 32'(instr_valid), 32'h1);
                chk("stall_req", 32'(imem_req), 32'h0);
                chk("stall_pc", pc, cur);
                chk("stall_instr", instruction, vecs[v].rdata);
                chk("stall_count", retire_count, cnt);
            end
            imem_ack = 1'b0;
            stall    = 1'b0;
            next_pc  = vecs[v].nxt;
            @(negedge clk);
            cnt = cnt + 32'd1;
            cur = vecs[v].exp_pc;
            chk("ret_count", retire_count, cnt);
            chk("ret_pc", pc, cur);
            chk("ret_req", 32'(imem_req), 32'h1);
            chk("ret_addr", imem_addr, cur);
        end

        // retire_count wrap from all-ones.
        apply_reset();
        fetch_one(32'hCAFE_0001);
        stall = 1'b1;
        force dut.r_retire_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_retire_count;
        @(negedge clk);
        chk("wrap_pre", retire_count, 32'hFFFF_FFFF);
        stall   = 1'b0;
        next_pc = 32'h0000_0008;
        @(negedge clk);
        chk("wrap_zero", retire_count, 32'h0);
        chk("wrap_pc", pc, 32'h0000_0008);

        // Misaligned retire target.
        apply_reset();
        fetch_one(32'h0000_000A);
        next_pc = 32'h0000_0100;
        @(negedge clk);
        fetch_one(32'h0000_000B);
        next_pc = 32'h0000_0102;
        @(negedge clk);
        chk("mis_count", retire_count, 32'd2);
        chk("mis_pc", pc, 32'h0000_0100);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_flag", 32'(misalign), 32'h1);
        for (int i = 0; i < 4; i++) begin
            imem_ack = 1'b1;
            stall    = 1'(i % 2);
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'h0);
            chk("halt_valid", 32'(instr_valid), 32'h0);
            chk("halt_pc", pc, 32'h0000_0100);
            chk("halt_count", retire_count, 32'd2);
            chk("halt_flag", 32'(misalign), 32'h1);
        end
        imem_ack = 1'b0;
        stall    = 1'b0;
`else
        chk("mis_flag", 32'(misalign), 32'h0);
        chk("mis_req", 32'(imem_req), 32'h1);
        chk("mis_addr", imem_addr, 32'h0000_0100);
`endif

        // Reset mid-FETCH; an ack arriving in IDLE must be ignored.
        apply_reset();
        @(negedge clk);
        chk("rf_req", 32'(imem_req), 32'h1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rf_async_req", 32'(imem_req), 32'h0);
        chk("rf_async_addr", imem_addr, RESET_PC);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        reset      = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("rf_fresh_req", 32'(imem_req), 32'h1);
        chk("rf_fresh_addr", imem_addr, RESET_PC);
        chk("rf_instr", instruction, 32'h0);
        chk("rf_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("rf_still_req", 32'(imem_req), 32'h1);
        chk("rf_still_valid", 32'(instr_valid), 32'h0);

        // Random latency/stall/spurious-ack run against a transaction scoreboard.
        apply_reset();
        cur       = RESET_PC;
        cnt       = 32'h0;
        exp_instr = 32'h0;
        prev_req  = 1'b0;
        lat       = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            chk("rnd_excl", 32'(imem_req & instr_valid), 32'h0);
            chk("rnd_misalign", 32'(misalign), 32'h0);
            stall      = ($urandom_range(0, 2) == 0);
            next_pc    = $urandom;
            imem_rdata = $urandom;
            imem_ack   = 1'b0;
            if (imem_req) begin
                if (!prev_req) lat = $urandom_range(0, 3);
                chk("rnd_addr", imem_addr, cur);
                if (lat == 0) begin
                    imem_ack  = 1'b1;
                    exp_instr = imem_rdata;
                end else begin
                    lat--;
                end
            end else begin
                imem_ack = 1'($urandom_range(0, 1));
            end
            if (instr_valid) begin
                chk("rnd_instr", instruction, exp_instr);
                chk("rnd_pc", pc, cur);
                chk("rnd_count", retire_count, cnt);
                if (!stall) begin
`ifdef PC_ALIGN_CHECK_EN
                    next_pc[1:0] = 2'b00;
`endif
                    cur = {next_pc[31:2], 2'b00};
                    cnt = cnt + 32'd1;
                end
            end
            prev_req = imem_req;
        end
        @(negedge clk);
        chk("rnd_final_count", retire_count, cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
